// File: rtl/alu_instr_encoder_if.sv
// Request/response bundle for the ALU instruction encoder: request fields in,
// encoded RV32I word plus illegal flag and illegal-request count out.
interface alu_instr_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alu_ctrl;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        imm_sel;
    logic [11:0] imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] instr;
    logic        illegal;
    logic [7:0]  illegal_cnt;

    modport master (
        output in_valid, alu_ctrl, rd, rs1, rs2, imm_sel, imm, out_ready,
        input  in_ready, out_valid, instr, illegal, illegal_cnt
    );

    modport slave (
        input  in_valid, alu_ctrl, rd, rs1, rs2, imm_sel, imm, out_ready,
        output in_ready, out_valid, instr, illegal, illegal_cnt
    );
endinterface

// File: rtl/alu_instr_encoder.sv
// Encodes ALU operation requests into RV32I OP / OP-IMM words, buffered in a
// 2-entry FIFO of {instr, illegal} with a saturating illegal-request counter.
module alu_instr_encoder (
    input  logic                clk,
    input  logic                rst_n,
    alu_instr_encoder_if.slave  bus
);
    localparam logic [31:0] NOP = 32'h00000013;

    logic [1:0]  count_reg;
    logic [1:0]  count_next;
    logic        head_reg;
    logic        wr_idx;
    logic        in_ready_reg;
    logic [7:0]  illegal_cnt_reg;
    logic [32:0] mem_reg [2];
    logic        push;
    logic        pop;
    logic        out_valid;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        is_shift;
    logic        enc_illegal;
    logic [31:0] enc_word;

    always_comb begin
        funct3      = 3'b000;
        funct7      = 7'b0000000;
        is_shift    = 1'b0;
        enc_illegal = 1'b0;
        enc_word    = NOP;
        case (bus.alu_ctrl)
            4'd0, 4'd1: funct3 = 3'b000;
            4'd2:       funct3 = 3'b111;
            4'd3:       funct3 = 3'b110;
            4'd4:       funct3 = 3'b100;
            4'd5:       begin funct3 = 3'b001; is_shift = 1'b1; end
            4'd6, 4'd7: begin funct3 = 3'b101; is_shift = 1'b1; end
            4'd8:       funct3 = 3'b010;
            4'd9:       funct3 = 3'b011;
            default:    enc_illegal = 1'b1;
        endcase
        if (bus.alu_ctrl == 4'd1 || bus.alu_ctrl == 4'd7)
            funct7 = 7'b0100000;
        // There is no SUBI in RV32I.
        if (bus.alu_ctrl == 4'd1 && bus.imm_sel)
            enc_illegal = 1'b1;
        if (!enc_illegal) begin
            if (!bus.imm_sel)
                enc_word = {funct7, bus.rs2, bus.rs1, funct3, bus.rd, 7'b0110011};
            else if (is_shift)
                enc_word = {funct7, bus.imm[4:0], bus.rs1, funct3, bus.rd, 7'b0010011};
            else
                enc_word = {bus.imm, bus.rs1, funct3, bus.rd, 7'b0010011};
        end
    end

    assign out_valid  = (count_reg != 2'd0);
    assign push       = bus.in_valid && in_ready_reg;
    assign pop        = out_valid && bus.out_ready;
    // Writing at head+occupancy makes push+pop at occupancy 1 land the new word at the new head.
    assign wr_idx     = head_reg ^ count_reg[0];
    assign count_next = count_reg + {1'b0, push} - {1'b0, pop};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg       <= 2'd0;
            head_reg        <= 1'b0;
            in_ready_reg    <= 1'b0;
            illegal_cnt_reg <= 8'd0;
            for (int i = 0; i < 2; i++)
                mem_reg[i] <= '0;
        end else begin
            count_reg    <= count_next;
            head_reg     <= head_reg ^ pop;
            in_ready_reg <= (count_next != 2'd2);
            if (push)
                mem_reg[wr_idx] <= {enc_word, enc_illegal};
            if (push && enc_illegal && illegal_cnt_reg != 8'hFF)
                illegal_cnt_reg <= illegal_cnt_reg + 8'd1;
        end
    end

    assign bus.in_ready    = in_ready_reg;
    assign bus.out_valid   = out_valid;
    assign bus.instr       = out_valid ? mem_reg[head_reg][32:1] : 32'h00000000;
    assign bus.illegal     = out_valid ? mem_reg[head_reg][0] : 1'b0;
    assign bus.illegal_cnt = illegal_cnt_reg;
endmodule

// File: tb/tb_alu_instr_encoder.sv
// Randomized and directed bench for alu_instr_encoder against a queue-based
// reference model of the FIFO and a table-driven RV32I encoder.
module tb_alu_instr_encoder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    alu_instr_encoder_if bus ();

    alu_instr_encoder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [32:0] mq[$];
    int          m_cnt = 0;
    bit          m_rdy = 1'b0;

    function automatic logic [32:0] model_enc(input logic [3:0] op, input logic [4:0] rd,
                                              input logic [4:0] rs1, input logic [4:0] rs2,
                                              input logic isel, input logic [11:0] imm);
        int          f3_tab[10] = '{0, 0, 7, 6, 4, 1, 5, 5, 2, 3};
        logic [2:0]  f3;
        logic [6:0]  f7;
        if (op > 4'd9 || (op == 4'd1 && isel))
            return {32'h00000013, 1'b1};
        f3 = 3'(f3_tab[op]);
        f7 = (op == 4'd1 || op == 4'd7) ? 7'h20 : 7'h00;
        if (!isel)
            return {f7, rs2, rs1, f3, rd, 7'h33, 1'b0};
        if (op >= 4'd5 && op <= 4'd7)
            return {f7, imm[4:0], rs1, f3, rd, 7'h13, 1'b0};
        return {imm, rs1, f3, rd, 7'h13, 1'b0};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_cnt = 0;
            m_rdy = 1'b0;
        end else begin
            bit acc;
            bit pp;
            logic [32:0] w;
            acc = bus.in_valid && m_rdy;
            pp  = (mq.size() > 0) && bus.out_ready;
            w   = model_enc(bus.alu_ctrl, bus.rd, bus.rs1, bus.rs2, bus.imm_sel, bus.imm);
            if (pp) void'(mq.pop_front());
            if (acc) begin
                mq.push_back(w);
                if (w[0] && m_cnt < 255) m_cnt++;
            end
            m_rdy = (mq.size() < 2);
        end
    end

    // Per-cycle compare on the falling edge
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
            chk("rst_in_ready", {31'b0, bus.in_ready}, 32'd0);
            chk("rst_instr", bus.instr, 32'd0);
            chk("rst_cnt", {24'b0, bus.illegal_cnt}, 32'd0);
        end else begin
            chk("in_ready", {31'b0, bus.in_ready}, {31'b0, m_rdy});
            chk("out_valid", {31'b0, bus.out_valid}, (mq.size() > 0) ? 32'd1 : 32'd0);
            chk("illegal_cnt", {24'b0, bus.illegal_cnt}, 32'(m_cnt));
            if (mq.size() > 0) begin
                chk("instr", bus.instr, mq[0][32:1]);
                chk("illegal", {31'b0, bus.illegal}, {31'b0, mq[0][0]});
            end
        end
    end

    task automatic set_req(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic isel, input logic [11:0] imm);
        bus.alu_ctrl = op;
        bus.rd       = rd;
        bus.rs1      = rs1;
        bus.rs2      = rs2;
        bus.imm_sel  = isel;
        bus.imm      = imm;
    endtask

    // Called at #1 after an edge; returns at #1 after the accepting edge.
    task automatic push_req(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                            input logic [4:0] rs2, input logic isel, input logic [11:0] imm);
        int n = 0;
        set_req(op, rd, rs1, rs2, isel, imm);
        bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("accept_timeout", {31'b0, bus.in_ready}, 32'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        set_req(4'd0, 5'd0, 5'd0, 5'd0, 1'b0, 12'd0);

        repeat (2) @(posedge clk);
        #2;
        chk("reset_in_ready", {31'b0, bus.in_ready}, 32'd0);
        chk("reset_out_valid", {31'b0, bus.out_valid}, 32'd0);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("first_edge_in_ready", {31'b0, bus.in_ready}, 32'd1);

        // Hand-computed encodings
        push_req(4'd0, 5'd3, 5'd1, 5'd2, 1'b0, 12'd0);
        chk("add_valid", {31'b0, bus.out_valid}, 32'd1);
        chk("add_instr", bus.instr, 32'h002081B3);
        chk("add_illegal", {31'b0, bus.illegal}, 32'd0);
        push_req(4'd1, 5'd3, 5'd1, 5'd2, 1'b0, 12'd0);
        chk("sub_instr", bus.instr, 32'h402081B3);
        push_req(4'd1, 5'd3, 5'd1, 5'd2, 1'b1, 12'd0);
        chk("subi_instr", bus.instr, 32'h00000013);
        chk("subi_illegal", {31'b0, bus.illegal}, 32'd1);
        chk("subi_cnt", {24'b0, bus.illegal_cnt}, 32'd1);
        push_req(4'd0, 5'd5, 5'd0, 5'd0, 1'b1, 12'hFFF);
        chk("addi_instr", bus.instr, 32'hFFF00293);
        push_req(4'd7, 5'd4, 5'd4, 5'd0, 1'b1, 12'hFE3);
        chk("srai_instr", bus.instr, 32'h40325213);
        @(posedge clk); #1;

        // Backpressure: two accepts fill the FIFO, third waits for a pop
        bus.out_ready = 1'b0;
        push_req(4'd0, 5'd3, 5'd1, 5'd2, 1'b0, 12'd0);
        push_req(4'd1, 5'd3, 5'd1, 5'd2, 1'b0, 12'd0);
        chk("full_in_ready", {31'b0, bus.in_ready}, 32'd0);
        set_req(4'd2, 5'd7, 5'd6, 5'd5, 1'b0, 12'd0);
        bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("stall_in_ready", {31'b0, bus.in_ready}, 32'd0);
            chk("stall_head", bus.instr, 32'h002081B3);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("drain_second", bus.instr, 32'h402081B3);
        chk("drain_in_ready", {31'b0, bus.in_ready}, 32'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk("third_head", bus.instr, 32'h005373B3);
        @(posedge clk); #1;

        // Saturating illegal counter
        for (int i = 0; i < 300; i++)
            push_req(4'd12, 5'(i), 5'(i + 1), 5'(i + 2), 1'(i), 12'(i * 7));
        @(posedge clk); #1;
        chk("cnt_saturated", {24'b0, bus.illegal_cnt}, 32'd255);

        // Asynchronous reset with two words stored
        bus.out_ready = 1'b0;
        push_req(4'd3, 5'd9, 5'd8, 5'd7, 1'b0, 12'd0);
        push_req(4'd4, 5'd1, 5'd2, 5'd3, 1'b1, 12'h123);
        #1 rst_n = 1'b0;
        #1;
        chk("async_out_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("async_cnt", {24'b0, bus.illegal_cnt}, 32'd0);
        chk("async_instr", bus.instr, 32'd0);
        #1 rst_n = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("no_stale_word", {31'b0, bus.out_valid}, 32'd0);
        end

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            bus.in_valid  = ($urandom_range(0, 9) < 7);
            bus.out_ready = ($urandom_range(0, 9) < 6);
            set_req(4'($urandom_range(0, 15)), 5'($urandom), 5'($urandom), 5'($urandom),
                    1'($urandom), 12'($urandom));
            @(posedge clk); #1;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("final_empty", {31'b0, bus.out_valid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
